keyrom_stream: RTL and testbench

//  Multi-key secure key store with a gated streaming read port. Holds NUM_KEYS keys of
//  KEY_WORDS words each in a synchronous-read ROM. On request it streams the selected key,

---
 rtl/keyrom_stream_pkg.sv | 16 +
 rtl/keyrom_stream_array.sv | 32 +++
 rtl/keyrom_stream.sv | 135 +++++++++++++
 tb/tb_keyrom_stream.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keyrom_stream_pkg.sv
// Shared definitions for the key ROM streamer: FSM state encodings, default fill word
// and the key-select width helper.
package keyrom_stream_pkg;

  typedef enum logic {
    KS_IDLE   = 1'b0,
    KS_STREAM = 1'b1
  } ks_state_e;

  localparam logic [15:0] KS_INIT_WORD = 16'hcccc;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/keyrom_stream_array.sv
// Read-only key storage with a registered read address; contents come from the
// INIT_IMAGE preload (word i at bits [i*DATA_W +: DATA_W]).
module keyrom_stream_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter logic [DEPTH*DATA_W-1:0] INIT_IMAGE = '0
) (
  input  logic              mclk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] rd_data
);

  (* rom_style = "block" *) logic [DATA_W-1:0] rom [DEPTH];
  logic [ADDR_W-1:0] addr_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign rom[i] = INIT_IMAGE[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr;
    end
  end

  assign rd_data = rom[addr_q];

endmodule

// File: rtl/keyrom_stream.sv
// Gated key store: streams one selected key, word 0 first, over valid/ready.
//   state     | meaning
//   KS_IDLE   | waiting for an accepted key_start; rejected starts pulse key_err
//   KS_STREAM | presenting word {sel_q, idx_q}; exits on last fire, abort or grant loss
module keyrom_stream
  import keyrom_stream_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int KEY_WORDS = 16,
  parameter int NUM_KEYS  = 2,
  parameter logic [DATA_W-1:0] INIT_WORD = DATA_W'(KS_INIT_WORD),
  parameter logic [NUM_KEYS*KEY_WORDS*DATA_W-1:0] INIT_IMAGE = {(NUM_KEYS*KEY_WORDS){INIT_WORD}},
  localparam int SEL_W = sel_width(NUM_KEYS)
) (
  input  logic              mclk,
  input  logic              reset_n,
  input  logic              key_start,
  input  logic [SEL_W-1:0]  key_sel,
  input  logic              key_grant,
  input  logic              key_abort,
  input  logic              lock_set,
  output logic              key_valid,
  input  logic              key_ready,
  output logic [DATA_W-1:0] key_data,
  output logic              key_last,
  output logic              key_busy,
  output logic              key_done,
  output logic              key_err,
  output logic              locked
);

  localparam int IDX_W  = $clog2(KEY_WORDS);
  localparam int DEPTH  = NUM_KEYS * KEY_WORDS;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(KEY_WORDS - 1);
  localparam logic [SEL_W:0]   SEL_LIMIT = (SEL_W+1)'(NUM_KEYS);

  ks_state_e         state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              locked_q, locked_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              fire;
  logic              start_ok;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  assign fire     = (state_q == KS_STREAM) && key_ready;
  assign start_ok = key_grant && !locked_q && ({1'b0, key_sel} < SEL_LIMIT);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    idx_d    = idx_q;
    locked_d = locked_q | lock_set;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      KS_IDLE: begin
        if (key_start) begin
          if (start_ok) begin
            state_d = KS_STREAM;
            sel_d   = key_sel;
            idx_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      KS_STREAM: begin
        // Grant loss outranks abort, which outranks a fire.
        if (!key_grant) begin
          state_d = KS_IDLE;
          idx_d   = '0;
          err_d   = 1'b1;
        end else if (key_abort) begin
          state_d = KS_IDLE;
          idx_d   = '0;
        end else if (fire) begin
          if (idx_q == IDX_LAST) begin
            state_d = KS_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = KS_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= KS_IDLE;
      sel_q    <= '0;
      idx_q    <= '0;
      locked_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      idx_q    <= idx_d;
      locked_q <= locked_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // The ROM registers the next address so its output tracks {sel_q, idx_q}.
  assign rom_addr = ADDR_W'({sel_d, idx_d});

  keyrom_stream_array #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .INIT_IMAGE(INIT_IMAGE)
  ) u_array (
    .mclk   (mclk),
    .reset_n(reset_n),
    .addr   (rom_addr),
    .rd_data(rom_data)
  );

  assign key_valid = (state_q == KS_STREAM);
  assign key_busy  = (state_q == KS_STREAM);
  assign key_data  = key_valid ? rom_data : '0;
  assign key_last  = key_valid && (idx_q == IDX_LAST);
  assign key_done  = done_q;
  assign key_err   = err_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_keyrom_stream.sv
// Scoreboard bench for keyrom_stream: stimulus queues expected words, a negedge
// monitor compares every presented word; a small second instance covers key range.
`timescale 1ns/1ps
module tb_keyrom_stream;

  localparam int DW = 16;
  localparam int KW = 16;
  localparam int NK = 2;

  function automatic logic [NK*KW*DW-1:0] mk_img();
    logic [NK*KW*DW-1:0] img;
    img = '0;
    for (int a = 0; a < NK*KW; a++)
      img[a*DW +: DW] = (a < KW) ? 16'hcccc : 16'ha500 + 16'(a - KW);
    return img;
  endfunction

  localparam logic [NK*KW*DW-1:0] IMG = mk_img();

  function automatic logic [15:0] exp_word(input int sel, input int i);
    if (sel == 0) return 16'hcccc;
    return 16'ha500 + 16'(i);
  endfunction

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic        mclk = 1'b0;
  logic        reset_n;
  logic        key_start, key_grant, key_abort, lock_set, key_ready;
  logic [0:0]  key_sel;
  logic        key_valid, key_last, key_busy, key_done, key_err, locked;
  logic [15:0] key_data;

  logic        t3_start, t3_grant, t3_abort, t3_lock, t3_ready;
  logic [1:0]  t3_sel;
  logic        t3_valid, t3_last, t3_busy, t3_done, t3_err, t3_locked;
  logic [15:0] t3_data;

  always #5 mclk = ~mclk;

  keyrom_stream #(.DATA_W(DW), .KEY_WORDS(KW), .NUM_KEYS(NK), .INIT_IMAGE(IMG)) dut (
    .mclk(mclk), .reset_n(reset_n), .key_start(key_start), .key_sel(key_sel),
    .key_grant(key_grant), .key_abort(key_abort), .lock_set(lock_set),
    .key_valid(key_valid), .key_ready(key_ready), .key_data(key_data),
    .key_last(key_last), .key_busy(key_busy), .key_done(key_done),
    .key_err(key_err), .locked(locked)
  );

  keyrom_stream #(.DATA_W(DW), .KEY_WORDS(2), .NUM_KEYS(3)) dut3 (
    .mclk(mclk), .reset_n(reset_n), .key_start(t3_start), .key_sel(t3_sel),
    .key_grant(t3_grant), .key_abort(t3_abort), .lock_set(t3_lock),
    .key_valid(t3_valid), .key_ready(t3_ready), .key_data(t3_data),
    .key_last(t3_last), .key_busy(t3_busy), .key_done(t3_done),
    .key_err(t3_err), .locked(t3_locked)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  // Monitor: every presented word must match the queue head; it pops on fire.
  initial begin
    exp_t e;
    forever begin
      @(negedge mclk);
      if (reset_n) begin
        if (!key_valid) begin
          check("idle_data", 32'(key_data), 0);
          check("idle_last", 32'(key_last), 0);
        end else begin
          check("word_available", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q[0];
            check("word_data", 32'(key_data), 32'(e.data));
            check("word_last", 32'(key_last), 32'(e.last));
            if (key_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // act: 0 none, 1 grant drop at word 5, 2 abort with ready at word 5, 3 lock_set at word 5
  task automatic run(input int sel, input int nexp, input bit bp, input int act,
                     output int cyc, output logic done, output logic err);
    int fired;
    bit acted;
    for (int i = 0; i < nexp; i++)
      exp_q.push_back('{data: exp_word(sel, i), last: (i == KW-1)});
    key_sel   = 1'(sel);
    key_start = 1'b1;
    step();
    key_start = 1'b0;
    cyc   = 1;
    fired = 0;
    acted = 1'b0;
    check("first_valid", 32'(key_valid), 1);
    if (bp) key_ready = 1'b0;
    while (key_busy && cyc < 100) begin
      if (!acted && act != 0 && key_valid && fired == 5) begin
        acted = 1'b1;
        case (act)
          1: begin key_grant = 1'b0; key_ready = 1'b0; end
          2: begin key_abort = 1'b1; key_ready = 1'b1; end
          default: lock_set = 1'b1;
        endcase
      end
      if (key_valid && key_ready) fired++;
      step();
      cyc++;
      key_grant = 1'b1;
      key_abort = 1'b0;
      lock_set  = 1'b0;
      if (act == 1 && acted) key_ready = 1'b1;
      if (bp) key_ready = ~key_ready;
    end
    check("stream_ended", 32'(key_busy), 0);
    done = key_done;
    err  = key_err;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    logic d, e;
    reset_n = 1'b0;
    key_start = 1'b0; key_sel = 1'b0; key_grant = 1'b1; key_abort = 1'b0;
    lock_set = 1'b0; key_ready = 1'b1;
    t3_start = 1'b0; t3_sel = 2'd0; t3_grant = 1'b1; t3_abort = 1'b0;
    t3_lock = 1'b0; t3_ready = 1'b1;
    #2;
    check("rst_valid",  32'(key_valid), 0);
    check("rst_data",   32'(key_data), 0);
    check("rst_last",   32'(key_last), 0);
    check("rst_busy",   32'(key_busy), 0);
    check("rst_done",   32'(key_done), 0);
    check("rst_err",    32'(key_err), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst3_valid", 32'(t3_valid), 0);
    check("rst3_data",  32'(t3_data), 0);
    #21;
    reset_n = 1'b1;
    step(); step();

    // Basic stream, key 0
    run(0, 16, 1'b0, 0, cyc, d, e);
    check("t1_cycles", 32'(cyc), 17);
    check("t1_done", 32'(d), 1);
    check("t1_err", 32'(e), 0);
    check("t1_queue", 32'(exp_q.size()), 0);
    step();
    check("t1_done_pulse", 32'(key_done), 0);
    check("t1_busy", 32'(key_busy), 0);

    // Backpressure: ready alternates, first valid cycle has ready low
    run(0, 16, 1'b1, 0, cyc, d, e);
    key_ready = 1'b1;
    check("t2_cycles", 32'(cyc), 33);
    check("t2_done", 32'(d), 1);
    check("t2_queue", 32'(exp_q.size()), 0);
    step();

    // Distinct pattern in key 1
    run(1, 16, 1'b0, 0, cyc, d, e);
    check("t3_cycles", 32'(cyc), 17);
    check("t3_done", 32'(d), 1);
    check("t3_queue", 32'(exp_q.size()), 0);
    step();

    // Grant loss at word 5
    run(1, 6, 1'b0, 1, cyc, d, e);
    check("t4_cycles", 32'(cyc), 7);
    check("t4_err", 32'(e), 1);
    check("t4_done", 32'(d), 0);
    check("t4_valid", 32'(key_valid), 0);
    check("t4_data", 32'(key_data), 0);
    check("t4_queue", 32'(exp_q.size()), 1);
    exp_q.delete();
    step();
    check("t4_err_pulse", 32'(key_err), 0);

    // Abort together with ready at word 5
    run(0, 6, 1'b0, 2, cyc, d, e);
    check("t5_cycles", 32'(cyc), 7);
    check("t5_err", 32'(e), 0);
    check("t5_done", 32'(d), 0);
    check("t5_queue", 32'(exp_q.size()), 0);
    step();

    // Lock mid-stream: stream completes, next start rejected
    run(0, 16, 1'b0, 3, cyc, d, e);
    check("t6_cycles", 32'(cyc), 17);
    check("t6_done", 32'(d), 1);
    check("t6_locked", 32'(locked), 1);
    step();
    key_sel = 1'b0;
    key_start = 1'b1;
    step();
    key_start = 1'b0;
    check("t6_rej_err", 32'(key_err), 1);
    check("t6_rej_valid", 32'(key_valid), 0);
    check("t6_rej_busy", 32'(key_busy), 0);
    check("t6_rej_locked", 32'(locked), 1);
    step();
    check("t6_err_pulse", 32'(key_err), 0);
    #2 reset_n = 1'b0;
    #1 check("t6_unlock", 32'(locked), 0);
    #2 reset_n = 1'b1;
    step();
    check("t6_unlock_hold", 32'(locked), 0);
    run(1, 16, 1'b0, 0, cyc, d, e);
    check("t6_restart_done", 32'(d), 1);
    check("t6_restart_queue", 32'(exp_q.size()), 0);
    step();

    // Asynchronous reset mid-stream
    for (int i = 0; i < KW; i++)
      exp_q.push_back('{data: exp_word(0, i), last: (i == KW-1)});
    key_sel = 1'b0;
    key_start = 1'b1;
    step();
    key_start = 1'b0;
    step(); step(); step();
    check("t7_pre_valid", 32'(key_valid), 1);
    #3 reset_n = 1'b0;
    #1;
    check("t7_valid", 32'(key_valid), 0);
    check("t7_data", 32'(key_data), 0);
    check("t7_last", 32'(key_last), 0);
    check("t7_busy", 32'(key_busy), 0);
    check("t7_done", 32'(key_done), 0);
    check("t7_err", 32'(key_err), 0);
    exp_q.delete();
    #10 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t7_idle_busy", 32'(key_busy), 0);
      check("t7_idle_valid", 32'(key_valid), 0);
    end
    run(0, 16, 1'b0, 0, cyc, d, e);
    check("t7_restart_cycles", 32'(cyc), 17);
    check("t7_restart_done", 32'(d), 1);
    step();

    // Out-of-range key select on a 3-key instance, then a legal 2-word stream
    t3_sel = 2'd3;
    t3_start = 1'b1;
    step();
    t3_start = 1'b0;
    check("k3_range_err", 32'(t3_err), 1);
    check("k3_range_valid", 32'(t3_valid), 0);
    step();
    check("k3_err_pulse", 32'(t3_err), 0);
    check("k3_idle_valid", 32'(t3_valid), 0);
    t3_sel = 2'd2;
    t3_start = 1'b1;
    step();
    t3_start = 1'b0;
    check("k3_w0_valid", 32'(t3_valid), 1);
    check("k3_w0_data", 32'(t3_data), 32'h0000cccc);
    check("k3_w0_last", 32'(t3_last), 0);
    step();
    check("k3_w1_valid", 32'(t3_valid), 1);
    check("k3_w1_data", 32'(t3_data), 32'h0000cccc);
    check("k3_w1_last", 32'(t3_last), 1);
    step();
    check("k3_done", 32'(t3_done), 1);
    check("k3_busy", 32'(t3_busy), 0);
    check("k3_end_data", 32'(t3_data), 0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
